window_fetch_ctrl: RTL and testbench

- Initiator/controller that drives windowBuffer's read and shift interface.
- Walks a 3x3 window over an IMG_W x IMG_H 8-bit image held in pixel memory, in serpentine order.
- Fetches each required pixel from memory and writes it into windowBuffer's slots through the start_read/read_done handshake.
- Issues shift commands through start_shift/shift_direc/shift_done, and presents each completed window to the Sobel stage with a valid/ready handshake.

---
 rtl/window_fetch_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_window_fetch_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : window_fetch_ctrl
// Function : serpentine 3x3 window walker that fills and shifts windowBuffer
// Revision : 1.0
// ============================================================================
module window_fetch_ctrl #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    input  logic [7:0]        mem_data,
    input  logic              mem_valid,
    output logic              start_read,
    output logic [7:0]        data_r,
    output logic [3:0]        count,
    input  logic              read_done,
    output logic              start_shift,
    output logic [1:0]        shift_direc,
    input  logic              shift_done,
    output logic              window_valid,
    input  logic              sobel_ready,
    output logic [7:0]        win_row,
    output logic [7:0]        win_col,
    output logic              busy,
    output logic              frame_done
);

    generate
        if (IMG_W < 3 || IMG_H < 3 || IMG_W > 258 || IMG_H > 258 ||
            (longint'(IMG_W) * longint'(IMG_H)) > (longint'(1) << ADDR_W)) begin : g_param_check
            $error("window_fetch_ctrl: illegal IMG_W/IMG_H/ADDR_W combination");
        end
    endgenerate

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        FETCH_REQ  = 4'd1,
        FETCH_WAIT = 4'd2,
        WB_WRITE   = 4'd3,
        WB_WAIT    = 4'd4,
        PRESENT    = 4'd5,
        SHIFT      = 4'd6,
        SHIFT_WAIT = 4'd7,
        DONE       = 4'd8
    } state_t;

    // The fill mode reuses the shift direction code; 00 means a full 9-slot fill.
    localparam logic [1:0] DIR_FILL  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [7:0] LAST_COL = 8'(IMG_W - 3);
    localparam logic [7:0] LAST_ROW = 8'(IMG_H - 3);
    localparam logic [7:0] END_COL  = (((IMG_H - 3) % 2) == 0) ? LAST_COL : 8'd0;

    state_t            state, state_nxt;
    logic [1:0]        mode, mode_nxt;
    logic [3:0]        idx, idx_nxt;
    logic [7:0]        row_nxt, col_nxt;
    logic [7:0]        data_nxt;
    logic [3:0]        count_nxt;
    logic [1:0]        direc_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] pix_row, pix_col;
    logic [3:0]        cur_slot, nxt_slot;
    logic              last_slot, last_window;

    // Bottom row is always fetched first so windowBuffer sees new rows in order.
    function automatic logic [3:0] slot_of(input logic [1:0] m, input logic [3:0] i);
        logic [3:0] s;
        s = 4'd0;
        case (m)
            DIR_FILL: begin
                case (i)
                    4'd0:    s = 4'd6;
                    4'd1:    s = 4'd7;
                    4'd2:    s = 4'd8;
                    4'd3:    s = 4'd3;
                    4'd4:    s = 4'd4;
                    4'd5:    s = 4'd5;
                    4'd6:    s = 4'd0;
                    4'd7:    s = 4'd1;
                    default: s = 4'd2;
                endcase
            end
            DIR_RIGHT: s = (i == 4'd0) ? 4'd8 : (i == 4'd1) ? 4'd5 : 4'd2;
            DIR_LEFT:  s = (i == 4'd0) ? 4'd6 : (i == 4'd1) ? 4'd3 : 4'd0;
            default:   s = (i == 4'd0) ? 4'd6 : (i == 4'd1) ? 4'd7 : 4'd8;
        endcase
        return s;
    endfunction

    always_comb begin
        cur_slot    = slot_of(mode, idx);
        last_slot   = (mode == DIR_FILL) ? (idx == 4'd8) : (idx == 4'd2);
        last_window = (win_row == LAST_ROW) && (win_col == END_COL);
        state_nxt   = state;
        mode_nxt    = mode;
        idx_nxt     = idx;
        row_nxt     = win_row;
        col_nxt     = win_col;
        data_nxt    = data_r;
        count_nxt   = count;
        direc_nxt   = shift_direc;
        addr_nxt    = mem_addr;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH_REQ;
                    mode_nxt  = DIR_FILL;
                    idx_nxt   = 4'd0;
                    row_nxt   = 8'd0;
                    col_nxt   = 8'd0;
                end
            end
            FETCH_REQ: state_nxt = FETCH_WAIT;
            FETCH_WAIT: begin
                if (mem_valid) begin
                    state_nxt = WB_WRITE;
                    data_nxt  = mem_data;
                    count_nxt = cur_slot;
                end
            end
            WB_WRITE: state_nxt = WB_WAIT;
            WB_WAIT: begin
                if (read_done) begin
                    if (last_slot) begin
                        state_nxt = PRESENT;
                    end else begin
                        state_nxt = FETCH_REQ;
                        idx_nxt   = idx + 4'd1;
                    end
                end
            end
            PRESENT: begin
                if (sobel_ready) begin
                    if (last_window) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SHIFT;
                        idx_nxt   = 4'd0;
                        if (!win_row[0] && (win_col < LAST_COL)) begin
                            direc_nxt = DIR_RIGHT;
                            col_nxt   = win_col + 8'd1;
                        end else if (win_row[0] && (win_col != 8'd0)) begin
                            direc_nxt = DIR_LEFT;
                            col_nxt   = win_col - 8'd1;
                        end else begin
                            direc_nxt = DIR_DOWN;
                            row_nxt   = win_row + 8'd1;
                        end
                        mode_nxt = direc_nxt;
                    end
                end
            end
            SHIFT: state_nxt = SHIFT_WAIT;
            SHIFT_WAIT: begin
                if (shift_done) state_nxt = FETCH_REQ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        nxt_slot = slot_of(mode_nxt, idx_nxt);
        pix_row  = ADDR_W'(row_nxt) + ADDR_W'(nxt_slot / 4'd3);
        pix_col  = ADDR_W'(col_nxt) + ADDR_W'(nxt_slot % 4'd3);
        if (state_nxt == FETCH_REQ) addr_nxt = pix_row * ADDR_W'(IMG_W) + pix_col;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            mode         <= DIR_FILL;
            idx          <= 4'd0;
            win_row      <= 8'd0;
            win_col      <= 8'd0;
            data_r       <= 8'd0;
            count        <= 4'd0;
            shift_direc  <= 2'b00;
            mem_addr     <= '0;
            mem_read_en  <= 1'b0;
            start_read   <= 1'b0;
            start_shift  <= 1'b0;
            window_valid <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            mode         <= mode_nxt;
            idx          <= idx_nxt;
            win_row      <= row_nxt;
            win_col      <= col_nxt;
            data_r       <= data_nxt;
            count        <= count_nxt;
            shift_direc  <= direc_nxt;
            mem_addr     <= addr_nxt;
            mem_read_en  <= (state_nxt == FETCH_REQ);
            start_read   <= (state_nxt == WB_WRITE);
            start_shift  <= (state_nxt == SHIFT);
            window_valid <= (state_nxt == PRESENT);
            frame_done   <= (state_nxt == DONE);
            busy         <= (state_nxt != IDLE) && (state_nxt != DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_window_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_fetch_ctrl
// Function : scoreboard bench for a 4x4 frame walk plus a table-driven 3x3 frame
// Revision : 1.0
// ============================================================================
module tb_window_fetch_ctrl;

    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic n_rst;

    // 4x4 instance
    logic        start, mem_read_en, mem_valid, start_read, read_done;
    logic        start_shift, shift_done, window_valid, sobel_ready, busy, frame_done;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data, data_r, win_row, win_col;
    logic [3:0]  count;
    logic [1:0]  shift_direc;

    // 3x3 instance
    logic        start3, mem_read_en3, mem_valid3, start_read3, read_done3;
    logic        start_shift3, shift_done3, window_valid3, sobel_ready3, busy3, frame_done3;
    logic [15:0] mem_addr3;
    logic [7:0]  mem_data3, data_r3, win_row3, win_col3;
    logic [3:0]  count3;
    logic [1:0]  shift_direc3;

    window_fetch_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(16)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
        .mem_data(mem_data), .mem_valid(mem_valid), .start_read(start_read), .data_r(data_r),
        .count(count), .read_done(read_done), .start_shift(start_shift), .shift_direc(shift_direc),
        .shift_done(shift_done), .window_valid(window_valid), .sobel_ready(sobel_ready),
        .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
    );

    window_fetch_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(16)) dut3 (
        .clk(clk), .n_rst(n_rst), .start(start3), .mem_addr(mem_addr3), .mem_read_en(mem_read_en3),
        .mem_data(mem_data3), .mem_valid(mem_valid3), .start_read(start_read3), .data_r(data_r3),
        .count(count3), .read_done(read_done3), .start_shift(start_shift3), .shift_direc(shift_direc3),
        .shift_done(shift_done3), .window_valid(window_valid3), .sobel_ready(sobel_ready3),
        .win_row(win_row3), .win_col(win_col3), .busy(busy3), .frame_done(frame_done3)
    );

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;
    localparam logic [1:0] EV_FETCH = 2'd0;
    localparam logic [1:0] EV_WIN   = 2'd1;
    localparam logic [1:0] EV_SHIFT = 2'd2;
    localparam logic [1:0] EV_DONE  = 2'd3;

    typedef struct packed {
        logic [7:0]  din;
        logic [3:0]  exp_count;
        logic [15:0] exp_addr;
    } vec_t;

    ev_t  sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;
    int   shift3_cnt = 0;
    int   fetch3_cnt = 0;
    int   mem_lat = 2;
    int   rd_lat = 1;
    int   sh_lat = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected event stream of one frame, derived from the window geometry.
    task automatic push_frame(input int w, input int h);
        int r, c, n, mode;
        r = 0; c = 0; mode = 0;
        n = (w - 2) * (h - 2);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 9; j++) begin
                int s;
                if (mode != 0 && j >= 3) break;
                if (mode == 0)      s = 3 * (2 - j / 3) + j % 3;
                else if (mode == 1) s = 3 * (2 - j) + 2;
                else if (mode == 3) s = 3 * (2 - j);
                else                s = 6 + j;
                sb.push_back(ev_t'{EV_FETCH, 8'(s), 8'((r + s / 3) * w + c + s % 3)});
            end
            sb.push_back(ev_t'{EV_WIN, 8'(r), 8'(c)});
            if (k == n - 1) begin
                sb.push_back(ev_t'{EV_DONE, 8'd0, 8'd0});
            end else begin
                if (r % 2 == 0 && c < w - 3)  begin mode = 1; c++; end
                else if (r % 2 == 1 && c > 0) begin mode = 3; c--; end
                else                          begin mode = 2; r++; end
                sb.push_back(ev_t'{EV_SHIFT, 8'(mode), 8'd0});
            end
        end
    endtask

    function automatic logic [63:0] outs4();
        return 64'({mem_addr, mem_read_en, start_read, data_r, count, start_shift, shift_direc,
                    window_valid, win_row, win_col, busy, frame_done});
    endfunction

    // Memory: returns addr[7:0] mem_lat cycles after the request.
    initial begin : mem_resp
        logic [15:0] a;
        mem_valid = 1'b0;
        mem_data  = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (mem_read_en) begin
                a = mem_addr;
                repeat (mem_lat) @(posedge clk);
                #1;
                mem_valid = 1'b1;
                mem_data  = a[7:0];
                @(posedge clk); #1;
                mem_valid = 1'b0;
            end
        end
    end

    initial begin : rd_resp
        logic [7:0] d;
        logic [3:0] c;
        read_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (start_read) begin
                d = data_r;
                c = count;
                for (int k = 0; k < rd_lat; k++) begin
                    @(posedge clk); #1;
                    check("rd_stall_start_read", 64'(start_read), 64'd0);
                    check("rd_stall_data_r", 64'(data_r), 64'(d));
                    check("rd_stall_count", 64'(count), 64'(c));
                end
                read_done = 1'b1;
                @(posedge clk); #1;
                read_done = 1'b0;
            end
        end
    end

    initial begin : sh_resp
        logic [1:0] dir;
        shift_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (start_shift) begin
                dir = shift_direc;
                for (int k = 0; k < sh_lat; k++) begin
                    @(posedge clk); #1;
                    check("sh_stall_start_shift", 64'(start_shift), 64'd0);
                    check("sh_stall_direc", 64'(shift_direc), 64'(dir));
                end
                shift_done = 1'b1;
                @(posedge clk); #1;
                shift_done = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic wv_prev;
        ev_t  e;
        wv_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (start_shift3) shift3_cnt++;
            if (mem_read_en3) fetch3_cnt++;
            if (start_read || (window_valid && !wv_prev) || start_shift || frame_done) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_event", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    if (start_read) begin
                        check("ev_kind_fetch", 64'(e.kind), 64'(EV_FETCH));
                        check("count", 64'(count), 64'(e.a));
                        check("data_r", 64'(data_r), 64'(e.b));
                    end else if (start_shift) begin
                        check("ev_kind_shift", 64'(e.kind), 64'(EV_SHIFT));
                        check("shift_direc", 64'(shift_direc), 64'(e.a));
                    end else if (frame_done) begin
                        check("ev_kind_done", 64'(e.kind), 64'(EV_DONE));
                        check("busy_at_frame_done", 64'(busy), 64'd0);
                        done_cnt++;
                    end else begin
                        check("ev_kind_window", 64'(e.kind), 64'(EV_WIN));
                        check("win_row", 64'(win_row), 64'(e.a));
                        check("win_col", 64'(win_col), 64'(e.b));
                    end
                end
            end
            wv_prev = window_valid;
        end
    end

    task automatic accept_window(input int stall);
        int t;
        logic [7:0] r0, c0;
        t = 0;
        while (!window_valid && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!window_valid) begin
            check("window_timeout", 64'(window_valid), 64'd1);
            return;
        end
        r0 = win_row;
        c0 = win_col;
        repeat (stall) begin
            @(posedge clk); #1;
            check("stall_window_valid", 64'(window_valid), 64'd1);
            check("stall_win_pos", 64'({win_row, win_col}), 64'({r0, c0}));
            check("stall_no_shift", 64'(start_shift), 64'd0);
        end
        sobel_ready = 1'b1;
        @(posedge clk); #1;
        sobel_ready = 1'b0;
    endtask

    task automatic run_frame(input int first_stall);
        push_frame(W, H);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        accept_window(first_stall);
        for (int k = 1; k < (W - 2) * (H - 2); k++) accept_window(0);
        check("frame_done_pulse", 64'(frame_done), 64'd1);
        check("busy_falls_with_done", 64'(busy), 64'd0);
    endtask

    task automatic run_3x3();
        vec_t tbl[9];
        int   t;
        tbl[0] = vec_t'{8'hA0, 4'd6, 16'd6};
        tbl[1] = vec_t'{8'h5A, 4'd7, 16'd7};
        tbl[2] = vec_t'{8'hFF, 4'd8, 16'd8};
        tbl[3] = vec_t'{8'h13, 4'd3, 16'd3};
        tbl[4] = vec_t'{8'h00, 4'd4, 16'd4};
        tbl[5] = vec_t'{8'h81, 4'd5, 16'd5};
        tbl[6] = vec_t'{8'h3C, 4'd0, 16'd0};
        tbl[7] = vec_t'{8'hC3, 4'd1, 16'd1};
        tbl[8] = vec_t'{8'h77, 4'd2, 16'd2};
        fetch3_cnt = 0;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            t = 0;
            while (!mem_read_en3 && t < 50) begin @(posedge clk); #1; t++; end
            check("f3_read_en", 64'(mem_read_en3), 64'd1);
            check("f3_addr", 64'(mem_addr3), 64'(tbl[i].exp_addr));
            @(posedge clk); #1;
            mem_valid3 = 1'b1;
            mem_data3  = tbl[i].din;
            @(posedge clk); #1;
            mem_valid3 = 1'b0;
            check("f3_start_read", 64'(start_read3), 64'd1);
            check("f3_count", 64'(count3), 64'(tbl[i].exp_count));
            check("f3_data_r", 64'(data_r3), 64'(tbl[i].din));
            @(posedge clk); #1;
            read_done3 = 1'b1;
            @(posedge clk); #1;
            read_done3 = 1'b0;
        end
        t = 0;
        while (!window_valid3 && t < 50) begin @(posedge clk); #1; t++; end
        check("f3_window_valid", 64'(window_valid3), 64'd1);
        check("f3_win_pos", 64'({win_row3, win_col3}), 64'd0);
        sobel_ready3 = 1'b1;
        @(posedge clk); #1;
        sobel_ready3 = 1'b0;
        check("f3_frame_done", 64'(frame_done3), 64'd1);
        check("f3_busy", 64'(busy3), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("f3_fetch_count", 64'(fetch3_cnt), 64'd9);
        check("f3_no_shift", 64'(shift3_cnt), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        n_rst = 1'b0;
        start = 1'b0; sobel_ready = 1'b0;
        start3 = 1'b0; sobel_ready3 = 1'b0; mem_valid3 = 1'b0; mem_data3 = 8'd0;
        read_done3 = 1'b0; shift_done3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs4(), 64'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Frame 1: fill, right move, serpentine, 10-cycle backpressure.
        run_frame(10);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("frame_done_one_cycle", 64'(frame_done), 64'd0);
        @(posedge clk); #1;
        check("start_on_done_ignored", 64'({busy, mem_read_en}), 64'd0);

        // Frame 2: stalled read_done/shift_done, start pulse while busy.
        mem_lat = 1; rd_lat = 4; sh_lat = 3;
        fork
            run_frame(0);
            begin
                repeat (5) @(posedge clk);
                #1;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        mem_lat = 2; rd_lat = 1; sh_lat = 1;
        repeat (2) @(posedge clk);
        #1;

        // Frame 3: reset during FETCH_WAIT with a late mem_valid.
        mem_lat = 4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("fetch_req_addr", 64'({mem_read_en, mem_addr}), 64'({1'b1, 16'd8}));
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        check("async_reset_outputs", outs4(), 64'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("late_mem_valid_ignored", outs4(), 64'd0);
        mem_lat = 2;

        // Frame 4: clean refill after reset.
        run_frame(0);
        repeat (2) @(posedge clk);
        #1;

        run_3x3();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        check("frames_completed", 64'(done_cnt), 64'd3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
